pla_vector_driver: RTL and testbench
====================================

Name: pla_vector_driver

Overview:
- Stimulus and response-capture engine for the combinational single-output PLA benchmark netlists, i.e. the other end of their x0..x15 -> y0 interface.
- Drives N_IN-bit input vectors, either exhaustive or pseudo-random.
- Samples the netlist's single output and compresses it into a serial signature plus a ones count.
- Used to compare an original PLA netlist against its optimised version by signature equality.

Parameters:
- N_IN, 16, input vector width; legal range 2..16.
- PIPE, 0, registered latency of the driven netlist in cycles (0 = purely combinational); legal range 0..7.
- POLY, 16'h1021, signature feedback polynomial (x^16 omitted).
- LFSR_TAPS, 16'hB400, Galois LFSR tap mask used for random mode.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- abort  in  1  terminate the current run immediately.
- mode  in  1  0 = exhaustive count 0..2^N_IN-1; 1 = LFSR for run_len vectors.
- seed  in  16  LFSR seed; a seed of 0 is replaced by 1.
- run_len  in  17  number of vectors in LFSR mode; ignored in exhaustive mode.
- sig_init  in  16  initial signature value, loaded on start.
- x_out  out  N_IN  vector driven to the netlist inputs (bit i -> input xi).
- y_in  in  1  netlist output y0.
- busy  out  1  high from the cycle after an accepted start until done or abort.
- done  out  1  one-cycle pulse when the run completes normally.
- signature  out  16  serial signature of the sampled y_in stream.
- ones_count  out  17  number of sampled y_in == 1.

Behaviour:
- Reset (async, any state): state IDLE; x_out, busy, done, signature, ones_count, internal counters and the valid pipe all go to 0.
- IDLE, start=1:
  - load the first vector into x_out: 0 in exhaustive mode, seed (or 1 if seed is 0) in LFSR mode;
  - signature <= sig_init; ones_count <= 0; busy <= 1; vector counter <= 0; go to RUN.
- IDLE, start=1, mode=1, run_len=0: no vectors are driven. Next cycle done=1 with signature=sig_init and ones_count=0; busy stays 0.
- RUN, one vector per cycle:
  - x_out advances every cycle: +1 in exhaustive mode; LFSR step in random mode, defined as lsb=x[0]; x>>=1; if lsb then x^=LFSR_TAPS (masked to N_IN bits).
  - A valid bit enters a PIPE-deep shift register with each vector.
  - y_in is sampled in the cycle the valid bit emerges, i.e. PIPE cycles after its vector was driven; PIPE=0 samples the same cycle.
- Sample update:
  - fb = signature[15] ^ y_in
  - signature <= (signature << 1) ^ (fb ? POLY : 0)
  - ones_count <= ones_count + y_in
- End of vectors: after the last vector is driven (2^N_IN vectors, or run_len), x_out holds its final value and the block goes to DRAIN.
- DRAIN: lasts until the valid pipe is empty (PIPE cycles; 0 when PIPE=0, so go directly to DONE).
- DONE:
  - done=1 for exactly one cycle, busy <= 0, return to IDLE.
  - signature and ones_count hold until the next accepted start.
- start while busy: ignored, no effect.
- abort in RUN or DRAIN: go to IDLE next cycle with busy=0 and no done pulse. The partial signature and ones_count remain visible.
- abort and start in the same IDLE cycle: abort wins and start is dropped.
- Exhaustive wrap: the counter is N_IN+1 bits wide so the 2^N_IN terminal count is exact; x_out never re-emits 0 within a run.
- ones_count saturates nowhere; 17 bits covers 65536 samples.

Test Plan:
- N_IN=4, PIPE=0, mode=0, y_in=x_out[0], sig_init=0 -> 16 busy cycles, x_out sequence 0..15, done at cycle 17, ones_count=8.
- N_IN=16, mode=0, y_in tied 1 -> ones_count=65536 at done; y_in tied 0 with sig_init=0 -> signature=16'h0000, ones_count=0.
- mode=1, run_len=1, sig_init=0, y_in=1 -> x_out=seed for one cycle, signature=16'h1021, ones_count=1; with seed=0, x_out=1.
- PIPE=3, N_IN=4, y_in driven by a 3-stage delay of x_out[3] -> ones_count=8, done exactly 3 cycles after the last vector, busy spans 19 cycles.
- Run with run_len=100, abort after 10 cycles -> busy=0 next cycle, no done, ones_count <= 10; start while busy mid-run -> no restart and sequence unchanged.
- Assert rst mid-RUN -> all outputs 0 asynchronously; a subsequent start begins a fresh run with correct values.

Source files
------------

// File: rtl/pla_vector_driver.sv
// pla_vector_driver: drives exhaustive/LFSR vectors into a PLA netlist and signs its single output
module pla_vector_driver #(
    parameter int          N_IN      = 16,
    parameter int          PIPE      = 0,
    parameter logic [15:0] POLY      = 16'h1021,
    parameter logic [15:0] LFSR_TAPS = 16'hB400
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            mode,
    input  logic [15:0]     seed,
    input  logic [16:0]     run_len,
    input  logic [15:0]     sig_init,
    output logic [N_IN-1:0] x_out,
    input  logic            y_in,
    output logic            busy,
    output logic            done,
    output logic [15:0]     signature,
    output logic [16:0]     ones_count
);
    localparam int PW = (PIPE > 0) ? PIPE : 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    state_t state_q, state_d;
    logic [N_IN-1:0] x_q, x_d, seed_n, lfsr_next;
    logic [16:0] cnt_q, cnt_d, ones_q, ones_d, len_q, len_d, last;
    logic [15:0] sig_q, sig_d;
    logic [PW-1:0] vp_q, vp_d;
    logic [2:0] dc_q, dc_d;
    logic busy_q, busy_d, done_q, done_d, mode_q, mode_d, samp, fb;
    assign seed_n    = (N_IN'(seed) == '0) ? N_IN'(1) : N_IN'(seed);
    assign lfsr_next = (x_q >> 1) ^ (x_q[0] ? LFSR_TAPS[N_IN-1:0] : '0);
    assign last      = mode_q ? len_q - 17'd1 : 17'((1 << N_IN) - 1);
    assign samp      = ((PIPE == 0) ? (state_q == RUN) : vp_q[PW-1]) && !abort;
    assign fb        = sig_q[15] ^ y_in;
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        ones_d  = ones_q;
        len_d   = len_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dc_d    = dc_q;
        vp_d    = (vp_q << 1) | PW'(state_q == RUN);
        if (samp) begin
            sig_d  = (sig_q << 1) ^ (fb ? POLY : 16'h0000);
            ones_d = ones_q + 17'(y_in);
        end
        case (state_q)
            IDLE: if (start && !abort) begin
                sig_d  = sig_init;
                ones_d = '0;
                cnt_d  = '0;
                dc_d   = '0;
                vp_d   = '0;
                mode_d = mode;
                len_d  = run_len;
                if (mode && run_len == '0) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    x_d     = mode ? seed_n : '0;
                end
            end
            RUN: if (cnt_q == last) begin
                state_d = (PIPE == 0) ? FIN : DRAIN;
                busy_d  = (PIPE != 0);
                done_d  = (PIPE == 0);
            end else begin
                cnt_d = cnt_q + 17'd1;
                x_d   = mode_q ? lfsr_next : x_q + N_IN'(1);
            end
            DRAIN: if (dc_q == 3'(PIPE - 1)) begin
                state_d = FIN;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                dc_d = dc_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
        // abort drops the in-flight samples but leaves the partial results visible
        if (abort && (state_q == RUN || state_q == DRAIN)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            vp_d    = '0;
            x_d     = x_q;
            sig_d   = sig_q;
            ones_d  = ones_q;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            sig_q   <= '0;
            ones_q  <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dc_q    <= '0;
            vp_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            ones_q  <= ones_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dc_q    <= dc_d;
            vp_q    <= vp_d;
        end
    end
    assign x_out      = x_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign signature  = sig_q;
    assign ones_count = ones_q;
endmodule

// File: tb/tb_pla_vector_driver.sv
// tb_pla_vector_driver: scoreboard bench for two 4-input drivers (combinational and 3-deep pipelined netlist)
module tb_pla_vector_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;
    logic start_a = 0, abort_a = 0, mode_a = 0, start_b = 0, abort_b = 0, mode_b = 0;
    logic [15:0] seed_a = 0, sig_init_a = 0, seed_b = 0, sig_init_b = 0;
    logic [16:0] run_len_a = 0, run_len_b = 0;
    logic [3:0] x_a, x_b;
    logic y_a, y_b, busy_a, done_a, busy_b, done_b;
    logic [15:0] sig_a, sig_b;
    logic [16:0] ones_a, ones_b;
    logic [2:0] dly;
    int ysel_a = 0;
    int checks = 0, errors = 0;
    logic [3:0] xq_a[$], xq_b[$], exp_x[$];
    logic [32:0] rq_a[$], rq_b[$];
    assign y_a = (ysel_a == 0) ? x_a[0] : (ysel_a == 1);
    assign y_b = dly[2];
    always @(posedge clk or posedge rst)
        if (rst) dly <= '0;
        else dly <= {dly[1:0], x_b[3]};
    pla_vector_driver #(.N_IN(4), .PIPE(0), .LFSR_TAPS(16'h000C)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .mode(mode_a), .seed(seed_a),
        .run_len(run_len_a), .sig_init(sig_init_a), .x_out(x_a), .y_in(y_a), .busy(busy_a),
        .done(done_a), .signature(sig_a), .ones_count(ones_a));
    pla_vector_driver #(.N_IN(4), .PIPE(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .mode(mode_b), .seed(seed_b),
        .run_len(run_len_b), .sig_init(sig_init_b), .x_out(x_b), .y_in(y_b), .busy(busy_b),
        .done(done_b), .signature(sig_b), .ones_count(ones_b));
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    function automatic logic [15:0] sig_step(input logic [15:0] s, input logic y);
        return (s << 1) ^ ((s[15] ^ y) ? 16'h1021 : 16'h0000);
    endfunction
    always @(negedge clk) begin
        logic [32:0] r;
        if (busy_a && xq_a.size() > 0) chk("x_a", x_a, xq_a.pop_front());
        if (busy_b && xq_b.size() > 0) chk("x_b", x_b, xq_b.pop_front());
        if (done_a) begin
            if (rq_a.size() == 0) chk("unexpected_done_a", done_a, 0);
            else begin
                r = rq_a.pop_front();
                chk("sig_a", sig_a, r[32:17]);
                chk("ones_a", ones_a, r[16:0]);
            end
        end
        if (done_b) begin
            if (rq_b.size() == 0) chk("unexpected_done_b", done_b, 0);
            else begin
                r = rq_b.pop_front();
                chk("sig_b", sig_b, r[32:17]);
                chk("ones_b", ones_b, r[16:0]);
            end
        end
    end
    task automatic fill_exh();
        exp_x.delete();
        for (int i = 0; i < 16; i++) exp_x.push_back(4'(i));
    endtask
    task automatic expect_run(input bit b, input int ys, input logic [15:0] si);
        logic [15:0] s;
        logic [16:0] o;
        logic y;
        s = si;
        o = '0;
        foreach (exp_x[i]) begin
            y = (ys == 0) ? exp_x[i][0] : (ys == 1) ? 1'b1 : (ys == 3) ? exp_x[i][3] : 1'b0;
            s = sig_step(s, y);
            o = o + 17'(y);
            if (b) xq_b.push_back(exp_x[i]);
            else xq_a.push_back(exp_x[i]);
        end
        if (b) rq_b.push_back({s, o});
        else rq_a.push_back({s, o});
    endtask
    task automatic pulse(input bit b, input logic m, input logic [15:0] sd, input logic [16:0] rl,
                         input logic [15:0] si);
        @(negedge clk);
        if (b) begin
            mode_b = m; seed_b = sd; run_len_b = rl; sig_init_b = si; start_b = 1;
        end else begin
            mode_a = m; seed_a = sd; run_len_a = rl; sig_init_a = si; start_a = 1;
        end
        @(negedge clk);
        start_a = 0;
        start_b = 0;
    endtask
    task automatic wait_done(input bit b, output int nb, output bit seen);
        nb = 0;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (b ? busy_b : busy_a) nb++;
            if (b ? done_b : done_a) seen = 1;
            else @(negedge clk);
        end
    endtask
    initial begin
        #100000;
        errors++;
        $display("FAIL global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
    initial begin
        int nb, dn;
        bit seen;
        #12;
        chk("rst_x", x_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_sig", sig_a, 0);
        chk("rst_ones", ones_a, 0);
        @(negedge clk);
        rst = 0;
        fill_exh(); ysel_a = 0; expect_run(0, 0, 16'h0000);
        pulse(0, 0, 0, 0, 16'h0000); wait_done(0, nb, seen);
        chk("exh_done", seen, 1); chk("exh_busy_cycles", nb, 16); chk("exh_ones", ones_a, 8);
        fill_exh(); ysel_a = 1; expect_run(0, 1, 16'h0000);
        pulse(0, 0, 0, 0, 16'h0000); wait_done(0, nb, seen);
        chk("ones1_done", seen, 1); chk("ones1_count", ones_a, 16);
        fill_exh(); ysel_a = 2; expect_run(0, 2, 16'h0000);
        pulse(0, 0, 0, 0, 16'h0000); wait_done(0, nb, seen);
        chk("zero_done", seen, 1); chk("zero_sig", sig_a, 0); chk("zero_ones", ones_a, 0);
        fill_exh(); ysel_a = 2; expect_run(0, 2, 16'h8000);
        pulse(0, 0, 0, 0, 16'h8000); wait_done(0, nb, seen);
        chk("init_done", seen, 1);
        ysel_a = 1; xq_a.push_back(4'h5); rq_a.push_back({16'h1021, 17'd1});
        pulse(0, 1, 16'h0005, 17'd1, 16'h0000); wait_done(0, nb, seen);
        chk("len1_done", seen, 1); chk("len1_busy", nb, 1);
        xq_a.push_back(4'h1); rq_a.push_back({16'h1021, 17'd1});
        pulse(0, 1, 16'h0000, 17'd1, 16'h0000); wait_done(0, nb, seen);
        chk("seed0_done", seen, 1);
        exp_x.delete(); exp_x = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD}; ysel_a = 0; expect_run(0, 0, 16'h0000);
        pulse(0, 1, 16'h0001, 17'd5, 16'h0000); wait_done(0, nb, seen);
        chk("lfsr_done", seen, 1); chk("lfsr_busy", nb, 5); chk("lfsr_ones", ones_a, 3);
        rq_a.push_back({16'hBEEF, 17'd0});
        pulse(0, 1, 16'h0001, 17'd0, 16'hBEEF); wait_done(0, nb, seen);
        chk("len0_done", seen, 1); chk("len0_busy", nb, 0);
        fill_exh(); ysel_a = 0; expect_run(0, 0, 16'h1234);
        pulse(0, 0, 0, 0, 16'h1234);
        repeat (5) @(negedge clk);
        start_a = 1; mode_a = 1;
        @(negedge clk); start_a = 0;
        wait_done(0, nb, seen);
        chk("restart_ignored_done", seen, 1);
        ysel_a = 1;
        pulse(0, 1, 16'h0001, 17'd100, 16'h0000);
        repeat (9) @(negedge clk);
        abort_a = 1;
        @(negedge clk); abort_a = 0;
        chk("abort_busy", busy_a, 0);
        chk("abort_ones_range", (ones_a >= 9 && ones_a <= 10), 1);
        dn = 0;
        repeat (20) @(negedge clk) if (done_a) dn++;
        chk("abort_no_done", dn, 0);
        @(negedge clk); start_a = 1; abort_a = 1; mode_a = 0;
        @(negedge clk); start_a = 0; abort_a = 0;
        chk("abort_beats_start", busy_a, 0);
        pulse(0, 0, 0, 0, 16'h0000);
        repeat (4) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_x", x_a, 0); chk("arst_busy", busy_a, 0); chk("arst_sig", sig_a, 0);
        chk("arst_ones", ones_a, 0); chk("arst_done", done_a, 0);
        @(negedge clk); rst = 0;
        fill_exh(); ysel_a = 0; expect_run(0, 0, 16'h0000);
        pulse(0, 0, 0, 0, 16'h0000); wait_done(0, nb, seen);
        chk("fresh_done", seen, 1); chk("fresh_busy", nb, 16); chk("fresh_ones", ones_a, 8);
        fill_exh(); expect_run(1, 3, 16'h0000);
        repeat (3) xq_b.push_back(4'hF);
        pulse(1, 0, 0, 0, 16'h0000); wait_done(1, nb, seen);
        chk("pipe_done", seen, 1); chk("pipe_busy", nb, 19); chk("pipe_ones", ones_b, 8);
        repeat (3) @(negedge clk);
        chk("xq_a_empty", xq_a.size(), 0); chk("xq_b_empty", xq_b.size(), 0);
        chk("rq_a_empty", rq_a.size(), 0); chk("rq_b_empty", rq_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
